pap_update_queue: RTL and testbench

Buffers resolved-branch results from the integer issue lanes and serialises them into one PAp predictor update per cycle. It sits between branch resolution in the execute/writeback stage and the PAp pattern/history tables. Each pop produces a saturated counter write value and, on a conditional misprediction, a history recovery write. This removes the multi-bank write conflicts that arise when several lanes update the same table in one cycle.

---
 rtl/pap_update_queue.sv | 132 +++++++++++++
 tb/tb_pap_update_queue.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pap_update_queue.sv
// Branch-result queue feeding the PAp predictor: accepts up to IN_WIDTH resolved
// branches per cycle and emits one counter update (plus optional history repair) per cycle.
module pap_update_queue #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned IN_WIDTH    = 2,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned INDEX_WIDTH = 10,
  parameter int unsigned HIST_WIDTH  = 10,
  parameter int unsigned CTR_WIDTH   = 2,
  parameter int unsigned INSN_SHIFT  = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [IN_WIDTH-1:0]            in_valid,
  input  logic [IN_WIDTH*ADDR_WIDTH-1:0] in_addr,
  input  logic [IN_WIDTH*HIST_WIDTH-1:0] in_hist,
  input  logic [IN_WIDTH*CTR_WIDTH-1:0]  in_ctr,
  input  logic [IN_WIDTH-1:0]            in_taken,
  input  logic [IN_WIDTH-1:0]            in_mispred,
  input  logic [IN_WIDTH-1:0]            in_is_cond,
  output logic                           in_ready,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [INDEX_WIDTH-1:0]         out_index,
  output logic [HIST_WIDTH-1:0]          out_hist,
  output logic [CTR_WIDTH-1:0]           out_ctr_new,
  output logic                           out_hist_we,
  output logic [HIST_WIDTH-1:0]          out_hist_new,
  output logic [$clog2(DEPTH):0]         count,
  output logic [15:0]                    drop_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;

  logic [INDEX_WIDTH-1:0] memIndex [DEPTH];
  logic [HIST_WIDTH-1:0]  memHist  [DEPTH];
  logic [CTR_WIDTH-1:0]   memCtr   [DEPTH];
  logic                   memTaken [DEPTH];
  logic                   memRecov [DEPTH];

  logic [PTR_W-1:0] headPtr;
  logic [PTR_W-1:0] tailPtr;
  logic [PTR_W-1:0] laneSlot [IN_WIDTH];
  logic [CNT_W-1:0] validCnt;
  logic [CNT_W-1:0] pushAmt;
  logic [CNT_W-1:0] popAmt;
  logic             doPush;
  logic             doPop;
  logic [16:0]      dropSum;

  // Only the index field of each address is consumed.
  logic unusedAddrBits;
  assign unusedAddrBits = ^in_addr;

  // Valid lanes pack into consecutive slots starting at the tail.
  always_comb begin
    validCnt = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      laneSlot[i] = tailPtr + PTR_W'(validCnt);
      validCnt    = validCnt + CNT_W'(in_valid[i]);
    end
  end

  assign in_ready  = (CNT_W'(DEPTH) - count) >= CNT_W'(IN_WIDTH);
  assign out_valid = (count != '0);
  assign doPush    = in_ready && !flush;
  assign doPop     = out_valid && out_ready && !flush;
  assign pushAmt   = doPush ? validCnt : '0;
  assign popAmt    = doPop ? CNT_W'(1) : '0;
  assign dropSum   = {1'b0, drop_cnt} + 17'(validCnt);

  always_ff @(posedge clk) begin
    if (doPush) begin
      for (int i = 0; i < IN_WIDTH; i++) begin
        if (in_valid[i]) begin
          memIndex[laneSlot[i]] <= in_addr[i*ADDR_WIDTH+INSN_SHIFT +: INDEX_WIDTH];
          memHist[laneSlot[i]]  <= in_hist[i*HIST_WIDTH +: HIST_WIDTH];
          memCtr[laneSlot[i]]   <= in_ctr[i*CTR_WIDTH +: CTR_WIDTH];
          memTaken[laneSlot[i]] <= in_taken[i];
          memRecov[laneSlot[i]] <= in_mispred[i] & in_is_cond[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      headPtr  <= '0;
      tailPtr  <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else if (flush) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      tailPtr <= tailPtr + PTR_W'(pushAmt);
      headPtr <= headPtr + PTR_W'(popAmt);
      count   <= count + pushAmt - popAmt;
      if (!in_ready && validCnt != '0) begin
        drop_cnt <= dropSum[16] ? 16'hFFFF : dropSum[15:0];
      end
    end
  end

  // Head-slot update values; everything reads zero while the queue is empty.
  logic [CTR_WIDTH-1:0] headCtr;
  logic                 headTaken;
  logic [CTR_WIDTH-1:0] ctrNext;

  assign headCtr   = memCtr[headPtr];
  assign headTaken = memTaken[headPtr];

  always_comb begin
    ctrNext = headCtr;
    if (headTaken) begin
      if (headCtr != CTR_MAX) ctrNext = headCtr + CTR_WIDTH'(1);
    end else begin
      if (headCtr != '0) ctrNext = headCtr - CTR_WIDTH'(1);
    end
  end

  assign out_index    = out_valid ? memIndex[headPtr] : '0;
  assign out_hist     = out_valid ? memHist[headPtr] : '0;
  assign out_ctr_new  = out_valid ? ctrNext : '0;
  assign out_hist_we  = out_valid && memRecov[headPtr];
  assign out_hist_new = out_valid ? {memHist[headPtr][HIST_WIDTH-1:1], headTaken} : '0;

endmodule

// File: tb/tb_pap_update_queue.sv
// Self-checking bench for pap_update_queue: directed vector table, corner sequences,
// and a randomized run against a queue-based reference model.
module tb_pap_update_queue;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned IW    = 2;
  localparam int unsigned AW    = 32;
  localparam int unsigned XW    = 10;
  localparam int unsigned HW    = 10;
  localparam int unsigned CW    = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [IW-1:0]     in_valid;
  logic [IW*AW-1:0]  in_addr;
  logic [IW*HW-1:0]  in_hist;
  logic [IW*CW-1:0]  in_ctr;
  logic [IW-1:0]     in_taken;
  logic [IW-1:0]     in_mispred;
  logic [IW-1:0]     in_is_cond;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [XW-1:0]     out_index;
  logic [HW-1:0]     out_hist;
  logic [CW-1:0]     out_ctr_new;
  logic              out_hist_we;
  logic [HW-1:0]     out_hist_new;
  logic [3:0]        count;
  logic [15:0]       drop_cnt;

  pap_update_queue dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_addr(in_addr), .in_hist(in_hist), .in_ctr(in_ctr),
    .in_taken(in_taken), .in_mispred(in_mispred), .in_is_cond(in_is_cond),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .out_hist(out_hist), .out_ctr_new(out_ctr_new),
    .out_hist_we(out_hist_we), .out_hist_new(out_hist_new),
    .count(count), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int nVec = 0;
  int nErr = 0;

  typedef struct {
    int          lane;
    logic [31:0] addr;
    logic [9:0]  hist;
    logic [1:0]  ctr;
    logic        taken;
    logic        mispred;
    logic        isCond;
    logic [9:0]  expIndex;
    logic [1:0]  expCtr;
    logic        expWe;
    logic [9:0]  expHistNew;
  } vec_t;

  typedef struct {
    int idx;
    int hist;
    int ctr;
    int taken;
    int recov;
  } ent_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearLanes();
    in_valid   = '0;
    in_addr    = '0;
    in_hist    = '0;
    in_ctr     = '0;
    in_taken   = '0;
    in_mispred = '0;
    in_is_cond = '0;
  endtask

  task automatic setLane(input int l, input logic [31:0] a, input logic [9:0] h,
                         input logic [1:0] c, input logic t, input logic m, input logic ic);
    in_valid[l]          = 1'b1;
    in_addr[l*AW +: AW]  = a;
    in_hist[l*HW +: HW]  = h;
    in_ctr[l*CW +: CW]   = c;
    in_taken[l]          = t;
    in_mispred[l]        = m;
    in_is_cond[l]        = ic;
  endtask

  // Sequence number s lands at table index s.
  task automatic pushPair(input int s);
    setLane(0, 32'(s * 4), 10'(s), 2'd1, 1'b1, 1'b0, 1'b1);
    setLane(1, 32'((s + 1) * 4), 10'(s + 1), 2'd1, 1'b1, 1'b0, 1'b1);
  endtask

  vec_t vecs[8];
  ent_t q[$];
  int   mDrop;

  initial begin
    vecs[0] = '{0, 32'h1004,     10'h005, 2'd2, 1'b1, 1'b0, 1'b1, 10'h001, 2'd3, 1'b0, 10'h005};
    vecs[1] = '{0, 32'h2000,     10'h100, 2'd3, 1'b1, 1'b0, 1'b1, 10'h000, 2'd3, 1'b0, 10'h101};
    vecs[2] = '{1, 32'h0FFC,     10'h3FF, 2'd0, 1'b0, 1'b0, 1'b1, 10'h3FF, 2'd0, 1'b0, 10'h3FE};
    vecs[3] = '{0, 32'h0008,     10'h001, 2'd1, 1'b0, 1'b0, 1'b1, 10'h002, 2'd0, 1'b0, 10'h000};
    vecs[4] = '{0, 32'h12345678, 10'h2AA, 2'd1, 1'b1, 1'b1, 1'b1, 10'h19E, 2'd2, 1'b1, 10'h2AB};
    vecs[5] = '{0, 32'h12345678, 10'h2AA, 2'd1, 1'b1, 1'b1, 1'b0, 10'h19E, 2'd2, 1'b0, 10'h2AB};
    vecs[6] = '{1, 32'h0400,     10'h2AB, 2'd2, 1'b0, 1'b1, 1'b1, 10'h100, 2'd1, 1'b1, 10'h2AA};
    vecs[7] = '{0, 32'h0004,     10'h000, 2'd2, 1'b0, 1'b0, 1'b0, 10'h001, 2'd1, 1'b0, 10'h000};

    rst = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    clearLanes();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_index", out_index, 0);
    rst = 1'b1;
    step();

    // Single-entry pushes into an empty queue, popped the following cycle.
    out_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      clearLanes();
      setLane(vecs[v].lane, vecs[v].addr, vecs[v].hist, vecs[v].ctr,
              vecs[v].taken, vecs[v].mispred, vecs[v].isCond);
      step();
      clearLanes();
      chk($sformatf("v%0d_valid", v), out_valid, 1);
      chk($sformatf("v%0d_count", v), count, 1);
      chk($sformatf("v%0d_index", v), out_index, vecs[v].expIndex);
      chk($sformatf("v%0d_hist", v), out_hist, vecs[v].hist);
      chk($sformatf("v%0d_ctr", v), out_ctr_new, vecs[v].expCtr);
      chk($sformatf("v%0d_we", v), out_hist_we, vecs[v].expWe);
      chk($sformatf("v%0d_hnew", v), out_hist_new, vecs[v].expHistNew);
      step();
      chk($sformatf("v%0d_empty", v), out_valid, 0);
      chk($sformatf("v%0d_zero", v), out_ctr_new, 0);
    end

    // Fill to DEPTH, overflow once, then drain in order.
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      clearLanes();
      pushPair(2 * c);
      step();
    end
    clearLanes();
    chk("fill_count", count, 8);
    chk("fill_ready", in_ready, 0);
    pushPair(100);
    step();
    clearLanes();
    chk("ovf_drop", drop_cnt, 2);
    chk("ovf_count", count, 8);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain_%0d", k), out_index, 10'(k));
      step();
    end
    chk("drain_empty", out_valid, 0);

    // Push and pop in the same cycle at count 6.
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      clearLanes();
      pushPair(20 + 2 * c);
      step();
    end
    clearLanes();
    chk("conc_pre", count, 6);
    pushPair(26);
    out_ready = 1'b1;
    step();
    clearLanes();
    chk("conc_count", count, 7);
    for (int k = 21; k < 28; k++) begin
      chk($sformatf("conc_%0d", k), out_index, 10'(k));
      step();
    end
    chk("conc_empty", out_valid, 0);

    // Flush beats a same-cycle push.
    out_ready = 1'b0;
    clearLanes(); pushPair(40); step();
    clearLanes(); pushPair(42); step();
    clearLanes(); setLane(0, 32'd44 * 4, 10'd0, 2'd0, 1'b0, 1'b0, 1'b0); step();
    clearLanes();
    chk("fl_pre", count, 5);
    pushPair(50);
    flush = 1'b1;
    step();
    flush = 1'b0;
    clearLanes();
    chk("fl_count", count, 0);
    chk("fl_valid", out_valid, 0);
    chk("fl_drop", drop_cnt, 2);
    step();
    chk("fl_count2", count, 0);

    // Asynchronous reset in the middle of a drain.
    clearLanes(); pushPair(60); step();
    clearLanes(); pushPair(62); step();
    clearLanes();
    out_ready = 1'b1;
    step();
    chk("ar_pre", count, 3);
    #2 rst = 1'b0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_count", count, 0);
    chk("ar_drop", drop_cnt, 0);
    step();
    rst = 1'b1;
    out_ready = 1'b0;
    step();

    // Randomized traffic against the reference queue.
    q.delete();
    mDrop = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      bit rdy;
      int nv;
      chk("rnd_valid", out_valid, 32'(q.size() != 0));
      chk("rnd_ready", in_ready, 32'((DEPTH - q.size()) >= IW));
      chk("rnd_count", count, 32'(q.size()));
      chk("rnd_drop", drop_cnt, 32'(mDrop));
      if (q.size() != 0) begin
        ent_t e;
        int expCtr;
        e = q[0];
        expCtr = e.taken ? ((e.ctr + 1 > 3) ? 3 : e.ctr + 1) : ((e.ctr - 1 < 0) ? 0 : e.ctr - 1);
        chk("rnd_index", out_index, 32'(e.idx));
        chk("rnd_hist", out_hist, 32'(e.hist));
        chk("rnd_ctr", out_ctr_new, 32'(expCtr));
        chk("rnd_we", out_hist_we, 32'(e.recov));
        chk("rnd_hnew", out_hist_new, 32'((e.hist / 2) * 2 + e.taken));
      end

      clearLanes();
      for (int l = 0; l < IW; l++) begin
        if ($urandom_range(0, 99) < 60) begin
          setLane(l, $urandom, 10'($urandom), 2'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom));
        end
      end
      out_ready = ($urandom_range(0, 99) < 45);
      flush = ($urandom_range(0, 99) < 3);

      rdy = (DEPTH - q.size()) >= IW;
      nv = 0;
      for (int l = 0; l < IW; l++) nv += int'(in_valid[l]);
      if (flush) begin
        q.delete();
      end else begin
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        if (rdy) begin
          for (int l = 0; l < IW; l++) begin
            if (in_valid[l]) begin
              ent_t n;
              n.idx   = int'((in_addr[l*AW +: AW] >> 2) % 1024);
              n.hist  = int'(in_hist[l*HW +: HW]);
              n.ctr   = int'(in_ctr[l*CW +: CW]);
              n.taken = int'(in_taken[l]);
              n.recov = int'(in_mispred[l] & in_is_cond[l]);
              q.push_back(n);
            end
          end
        end else begin
          mDrop = (mDrop + nv > 65535) ? 65535 : mDrop + nv;
        end
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
